// File: rtl/scariv_pkg.sv
// Shared configuration and credit types for the scariv dispatch credit masters.
package scariv_pkg;

    localparam int RV_FPU_ENTRY_SIZE = 16;
    localparam int FPU_DISP_SIZE     = 2;

    localparam int FPU_CRED_CNT_W = $clog2(RV_FPU_ENTRY_SIZE + 1);
    localparam int FPU_CRED_REQ_W = $clog2(FPU_DISP_SIZE + 1);

    typedef logic [FPU_CRED_CNT_W-1:0] fpu_cred_cnt_t;

endpackage

// File: rtl/scariv_credit_ret_stage.sv
// One-cycle register stage for credit returns from an issue unit.
// The registered count is zero whenever the registered strobe is low.
module scariv_credit_ret_stage #(
    parameter int CNT_W = 5
) (
    input  logic             i_clk,
    input  logic             i_reset_n,
    input  logic             i_valid,
    input  logic [CNT_W-1:0] i_cnt,
    output logic             o_valid,
    output logic [CNT_W-1:0] o_cnt
);

    logic             valid_q, valid_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        valid_d = i_valid;
        cnt_d   = i_valid ? i_cnt : '0;
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            valid_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
        end
    end

    assign o_valid = valid_q;
    assign o_cnt   = cnt_q;

endmodule

// File: rtl/scariv_fpu_credit_master.sv
// Dispatch-side credit master for one FPU reservation station.
// Define SCARIV_FPU_CREDIT_PERF_EN to add stall-cycle and low-watermark counters.
module scariv_fpu_credit_master
    import scariv_pkg::*;
#(
    parameter int ENTRY_SIZE = RV_FPU_ENTRY_SIZE,
    parameter int PORT_SIZE  = FPU_DISP_SIZE,
    localparam int CNT_W     = $clog2(ENTRY_SIZE + 1),
    localparam int REQ_W     = $clog2(PORT_SIZE + 1)
) (
    input  logic             i_clk,
    input  logic             i_reset_n,
    input  logic [REQ_W-1:0] i_disp_req_cnt,
    output logic             o_credit_ok,
    input  logic             i_disp_fire,
    input  logic             i_ret_valid,
    input  logic [CNT_W-1:0] i_ret_cnt,
    output logic [CNT_W-1:0] o_free_cnt,
    output logic             o_all_free,
`ifdef SCARIV_FPU_CREDIT_PERF_EN
    output logic [31:0]      o_perf_stall_cnt,
    output logic [CNT_W-1:0] o_perf_min_free,
`endif
    output logic             o_error
);

    localparam int SUM_W = CNT_W + 2;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(ENTRY_SIZE);

    logic             stage_valid;
    logic [CNT_W-1:0] stage_cnt;

    logic [CNT_W-1:0] free_cnt_q, free_cnt_d;
    logic             error_q, error_d;

    logic [CNT_W-1:0] req_cnt;
    logic [CNT_W-1:0] cons_cnt;
    logic [CNT_W-1:0] add_cnt;
    logic [SUM_W-1:0] sum;
    logic             sum_neg;
    logic             overflow;
    logic             underflow;
    logic             zero_ret;

    scariv_credit_ret_stage #(
        .CNT_W (CNT_W)
    ) u_ret_stage (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_valid   (i_ret_valid),
        .i_cnt     (i_ret_cnt),
        .o_valid   (stage_valid),
        .o_cnt     (stage_cnt)
    );

    assign req_cnt     = CNT_W'(i_disp_req_cnt);
    // Only the registered count gates dispatch; staged returns are not forwarded.
    assign o_credit_ok = (free_cnt_q >= req_cnt);

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        cons_cnt   = i_disp_fire ? req_cnt : '0;
        add_cnt    = stage_valid ? stage_cnt : '0;
        // Two guard bits: the MSB marks a negative result, the next one catches overflow.
        sum        = SUM_W'(free_cnt_q) - SUM_W'(cons_cnt) + SUM_W'(add_cnt);
        sum_neg    = sum[SUM_W-1];
        overflow   = !sum_neg && (sum > SUM_W'(ENTRY_SIZE));
        underflow  = i_disp_fire && !o_credit_ok;
        zero_ret   = i_ret_valid && (i_ret_cnt == '0);

        free_cnt_d = sum[CNT_W-1:0];
        if (sum_neg) begin
            free_cnt_d = '0;
        end else if (overflow) begin
            free_cnt_d = FULL_CNT;
        end

        error_d = error_q || underflow || overflow || zero_ret;
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            free_cnt_q <= FULL_CNT;
            error_q    <= 1'b0;
        end else begin
            free_cnt_q <= free_cnt_d;
            error_q    <= error_d;
        end
    end

    assign o_free_cnt = free_cnt_q;
    assign o_all_free = (free_cnt_q == FULL_CNT) && !stage_valid && !i_ret_valid;
    assign o_error    = error_q;

`ifdef SCARIV_FPU_CREDIT_PERF_EN
    logic [31:0]      stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] min_free_q, min_free_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if ((req_cnt != '0) && !o_credit_ok && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
        min_free_d = (free_cnt_d < min_free_q) ? free_cnt_d : min_free_q;
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            stall_cnt_q <= '0;
            min_free_q  <= FULL_CNT;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            min_free_q  <= min_free_d;
        end
    end

    assign o_perf_stall_cnt = stall_cnt_q;
    assign o_perf_min_free  = min_free_q;
`endif

endmodule

// File: tb/tb_scariv_fpu_credit_master.sv
// Randomized and directed scoreboard bench for scariv_fpu_credit_master.
module tb_scariv_fpu_credit_master;

    localparam int ENTRIES = 16;

    logic       i_clk;
    logic       i_reset_n;
    logic [1:0] i_disp_req_cnt;
    logic       o_credit_ok;
    logic       i_disp_fire;
    logic       i_ret_valid;
    logic [4:0] i_ret_cnt;
    logic [4:0] o_free_cnt;
    logic       o_all_free;
    logic       o_error;
`ifdef SCARIV_FPU_CREDIT_PERF_EN
    logic [31:0] o_perf_stall_cnt;
    logic [4:0]  o_perf_min_free;
`endif

    scariv_fpu_credit_master dut (
        .i_clk            (i_clk),
        .i_reset_n        (i_reset_n),
        .i_disp_req_cnt   (i_disp_req_cnt),
        .o_credit_ok      (o_credit_ok),
        .i_disp_fire      (i_disp_fire),
        .i_ret_valid      (i_ret_valid),
        .i_ret_cnt        (i_ret_cnt),
        .o_free_cnt       (o_free_cnt),
        .o_all_free       (o_all_free),
`ifdef SCARIV_FPU_CREDIT_PERF_EN
        .o_perf_stall_cnt (o_perf_stall_cnt),
        .o_perf_min_free  (o_perf_min_free),
`endif
        .o_error          (o_error)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    typedef struct {
        int ok;
        int all_free;
        int free;
        int err;
        int stall;
        int min_free;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference model: free credits, credits in flight to the counter, sticky error.
    int m_free = ENTRIES;
    int m_inflight[$];
    int m_err = 0;
    int m_stall = 0;
    int m_min = ENTRIES;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Returns strobed at cycle N land in the free count seen at cycle N+2.
    function automatic int model_landing();
        int v;
        v = 0;
        if (m_inflight.size() > 0 && m_inflight[0] >= 0) v = m_inflight[0];
        return v;
    endfunction

    task automatic step(input bit rst, input int req, input bit fire, input bit rv, input int rc);
        exp_t e;
        int nxt;
        @(posedge i_clk);
        #1;
        i_reset_n      = !rst;
        i_disp_req_cnt = 2'(req);
        i_disp_fire    = fire;
        i_ret_valid    = rv;
        i_ret_cnt      = 5'(rc);
        if (rst) begin
            m_free = ENTRIES;
            m_inflight.delete();
            m_err = 0;
            m_stall = 0;
            m_min = ENTRIES;
        end
        if (m_free < m_min) m_min = m_free;
        e.ok       = (m_free >= req);
        e.all_free = (m_free == ENTRIES && m_inflight.size() == 0 && !rv);
        e.free     = m_free;
        e.err      = m_err;
        e.stall    = m_stall;
        e.min_free = m_min;
        sb.push_back(e);
        if (!rst) begin
            if (req != 0 && !e.ok) m_stall++;
            if (fire && !e.ok) m_err = 1;
            if (rv && rc == 0) m_err = 1;
            nxt = m_free - (fire ? req : 0) + model_landing();
            if (m_inflight.size() > 0) void'(m_inflight.pop_front());
            if (rv) m_inflight.push_back(rc);
            if (nxt > ENTRIES) begin
                m_err = 1;
                nxt = ENTRIES;
            end
            if (nxt < 0) nxt = 0;
            m_free = nxt;
        end
    endtask

    // Monitor: compares every sampled cycle against the queued expectation.
    always @(negedge i_clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            check("credit_ok", int'(o_credit_ok), e.ok);
            check("all_free",  int'(o_all_free),  e.all_free);
            check("free_cnt",  int'(o_free_cnt),  e.free);
            check("error",     int'(o_error),     e.err);
`ifdef SCARIV_FPU_CREDIT_PERF_EN
            check("perf_stall", int'(o_perf_stall_cnt), e.stall);
            check("perf_min",   int'(o_perf_min_free),  e.min_free);
`endif
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int req, lim, rc;
        bit fire, rv;

        i_reset_n = 1'b0;
        i_disp_req_cnt = '0;
        i_disp_fire = 1'b0;
        i_ret_valid = 1'b0;
        i_ret_cnt = '0;

        step(1, 0, 0, 0, 0);
        step(1, 2, 0, 0, 0);
        step(0, 2, 0, 0, 0);

        // Drain all credits, then probe the empty boundary.
        repeat (8) step(0, 2, 1, 0, 0);
        step(0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0);
        repeat (4) step(0, 1, 0, 0, 0);

        // Two-cycle return latency from empty.
        step(0, 2, 0, 1, 3);
        step(0, 2, 0, 0, 0);
        step(0, 2, 0, 0, 0);

        // Reach free=5, then consume 2 while 1 lands.
        step(0, 0, 0, 1, 2);
        step(0, 0, 0, 1, 1);
        step(0, 2, 1, 0, 0);
        step(0, 0, 0, 0, 0);

        // Full drain and a single full return.
        step(1, 0, 0, 0, 0);
        repeat (8) step(0, 2, 1, 0, 0);
        step(0, 0, 0, 1, 16);
        repeat (3) step(0, 0, 0, 0, 0);

        // Legal random traffic.
        for (int i = 0; i < 400; i++) begin
            req  = int'($urandom_range(0, 2));
            fire = ($urandom_range(0, 3) != 0) && (m_free >= req);
            lim  = ENTRIES - m_free;
            foreach (m_inflight[k]) lim -= m_inflight[k];
            rv   = ($urandom_range(0, 2) == 0) && (lim > 0);
            rc   = rv ? int'($urandom_range(1, lim)) : 0;
            step(0, req, fire, rv, rc);
        end

        // Reset mid-operation discards a staged return.
        step(0, 2, 1, 0, 0);
        step(0, 0, 0, 1, 2);
        step(1, 0, 0, 0, 0);
        repeat (3) step(0, 0, 0, 0, 0);

        // Underflow: fire 2 at free=1, error stays through returns.
        repeat (7) step(0, 2, 1, 0, 0);
        step(0, 1, 1, 0, 0);
        step(0, 2, 1, 0, 0);
        step(0, 0, 0, 1, 4);
        repeat (3) step(0, 2, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);

        // Overflow at full.
        step(0, 0, 0, 1, 1);
        repeat (3) step(0, 1, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);

        // Zero-count return strobe.
        step(0, 2, 1, 0, 0);
        step(0, 0, 0, 1, 0);
        repeat (3) step(0, 0, 0, 0, 0);

        for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge i_clk);
        if (sb.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: got %0d pending expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
